// File: rtl/up_counter_bounded_if.sv
// Bus bundle for up_counter_bounded: count enable in, count/at_max/overflow out.
// The master drives the enable; the slave (the counter) drives the status.
interface up_counter_bounded_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             overflow;

    modport master (
        output en,
        input  count,
        input  at_max,
        input  overflow
    );

    modport slave (
        input  en,
        output count,
        output at_max,
        output overflow
    );
endinterface

// File: rtl/up_counter_bounded.sv
// Bounded up-counter that saturates at MAX and pulses overflow on enabled edges at MAX.
// Defining UP_COUNTER_WRAP_EN makes the counter wrap to 0 after MAX instead of saturating.
module up_counter_bounded #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    up_counter_bounded_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    generate
        if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
            $error("up_counter_bounded: MAX=%0d outside 1..2^WIDTH-1 for WIDTH=%0d", MAX, WIDTH);
        end
    endgenerate

    // Power-up values match the post-reset state; the parent may never assert reset first.
    logic [WIDTH-1:0] r_count    = '0;
    logic             r_overflow = 1'b0;
    logic             w_at_max;
    logic [WIDTH-1:0] w_count_nxt;

    // Equality compare against MAX so MAX = 2^WIDTH-1 needs no carry-out.
    assign w_at_max = (r_count == MAX_V);

    always_comb begin
        w_count_nxt = r_count + WIDTH'(1);
        if (w_at_max) begin
`ifdef UP_COUNTER_WRAP_EN
            w_count_nxt = '0;
`else
            w_count_nxt = MAX_V;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.en) begin
            r_count    <= w_count_nxt;
            r_overflow <= w_at_max;
        end else begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.count    = r_count;
    assign bus.at_max   = w_at_max;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_up_counter_bounded.sv
// Bench for up_counter_bounded: directed test-plan steps plus random en/rst traffic,
// checked against an arithmetic reference model for a MAX=9 and a MAX=15 instance.
module tb_up_counter_bounded;
    localparam int WIDTH = 4;
    localparam int MAX_A = 9;
    localparam int MAX_B = 15;
`ifdef UP_COUNTER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;
    bit   exp_ov_a = 1'b0;
    bit   exp_ov_b = 1'b0;

    always #5 clk = ~clk;

    up_counter_bounded_if #(.WIDTH(WIDTH)) if_a ();
    up_counter_bounded_if #(.WIDTH(WIDTH)) if_b ();

    up_counter_bounded #(.WIDTH(WIDTH), .MAX(MAX_A)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_a.slave)
    );

    up_counter_bounded #(.WIDTH(WIDTH), .MAX(MAX_B)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_b.slave)
    );

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all();
        check("a_count",    int'(if_a.count),    exp_cnt_a);
        check("a_at_max",   int'(if_a.at_max),   int'(exp_cnt_a == MAX_A));
        check("a_overflow", int'(if_a.overflow), int'(exp_ov_a));
        check("b_count",    int'(if_b.count),    exp_cnt_b);
        check("b_at_max",   int'(if_b.at_max),   int'(exp_cnt_b == MAX_B));
        check("b_overflow", int'(if_b.overflow), int'(exp_ov_b));
    endtask

    // Reference rule: reset clears; an enabled edge at MAX saturates (or wraps) and flags overflow.
    function automatic int next_cnt(input int c, input int mx, input bit e, input bit r);
        if (r) return 0;
        if (!e) return c;
        if (c == mx) return WRAP ? 0 : mx;
        return c + 1;
    endfunction

    task automatic step(input bit e, input bit r);
        if_a.en = e;
        if_b.en = e;
        rst     = r;
        @(posedge clk);
        exp_ov_a  = !r && e && (exp_cnt_a == MAX_A);
        exp_ov_b  = !r && e && (exp_cnt_b == MAX_B);
        exp_cnt_a = next_cnt(exp_cnt_a, MAX_A, e, r);
        exp_cnt_b = next_cnt(exp_cnt_b, MAX_B, e, r);
        #1;
        check_all();
    endtask

    initial begin
        if_a.en = 1'b0;
        if_b.en = 1'b0;
        #1;
        check_all();

        // Reset then hold
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);

        // Count to terminal on the MAX=9 instance, then keep enabling at MAX
        repeat (9) step(1'b1, 1'b0);
        check("a_terminal_9", int'(if_a.count), 9);
        repeat (3) step(1'b1, 1'b0);
        check("a_after_extra", int'(if_a.count), WRAP ? 2 : 9);

        // Priority and mid-count reset
        step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("a_prio_reset", int'(if_a.count), 0);
        repeat (2) step(1'b1, 1'b0);
        check("a_after_prio", int'(if_a.count), 2);

        // Enable gating from 3
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step((i % 2) == 0, 1'b0);
        check("a_gated", int'(if_a.count), 6);

        // Full-range corner on the MAX=15 instance
        step(1'b0, 1'b1);
        repeat (16) step(1'b1, 1'b0);
        check("b_full_range_ov", int'(if_b.overflow), 1);
        step(1'b0, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
